i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Byte-level I2C initiator. It complements the on-board I2C responder and lets the CPLD drive a local I2C bus itself, e.g. for sensor or EEPROM access.
- Software controls it through the shared 8-bit CSR bus (5-bit address, OR-combined read data). The top level instantiates it next to the pwm and gpio blocks.
- Open-drain pins are built in the top level: pad = oe ? 0 : z, and the pad value feeds back on the *_in inputs.

Parameters:
- BASE_ADDR, 5'h18: CSR base address. The block occupies BASE_ADDR+0..+2.
- DEFAULT_PRESCALE, 8'd13: reset value of PRESCALE. One quarter SCL period lasts (PRESCALE+1) clk cycles. The default gives about 100 kHz at the 5.5 MHz internal oscillator.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous and active-low
- csr_a  in  5  CSR address
- csr_di  in  8  CSR write data
- csr_we  in  1  CSR write strobe, one cycle
- csr_do  out  8  CSR read data; 0 when not addressed
- scl_in  in  1  SCL pad level
- scl_oe  out  1  1 = pull SCL low
- sda_in  in  1  SDA pad level
- sda_oe  out  1  1 = pull SDA low
- irq  out  1  level interrupt = DONE & IE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - scl_oe=0, sda_oe=0, csr_do=0, irq=0
  - PRESCALE=DEFAULT_PRESCALE; TXDATA, RXDATA and CTRL bits = 0
  - FSM goes to IDLE. Reset mid-transfer releases both lines on the next edge; no STOP is generated.
- CSR map:
  - +0 CTRL write: [0] START, [1] STOP, [2] READ, [3] WRITE, [4] MACK (0=ACK, 1=NACK sent after a read), [7] IE (sticky).
  - +0 STATUS read: [0] BUSY, [1] RXACK (0 = slave acked), [2] DONE, [7] IE.
  - +1 DATA: write = TXDATA, read = RXDATA.
  - +2 PRESCALE: read/write.
- csr_do is registered: it is valid the cycle after csr_a is presented, and 0 for any other address.
- Writes while BUSY:
  - CTRL writes update IE only; command bits are ignored.
  - DATA and PRESCALE writes are ignored.
- Command issue:
  - A CTRL write with BUSY=0 and any of bits [3:0] set sets BUSY on the next cycle and clears DONE.
  - A CTRL write with bits [3:0]=0 only updates IE and clears DONE.
- Command sequence: optional START, then one byte phase, then optional STOP, then DONE=1 and BUSY=0.
  - WRITE and READ both set: WRITE wins, READ is ignored.
  - Neither set: no byte phase (bare START and/or STOP).
- Timing: every state is split into quarters Q0..Q3 of (PRESCALE+1) clks each, counted by a down-counter reloaded per quarter.
- FSM states: IDLE, START, BIT, ACK, STOP.
  - START: Q0 release SDA; Q1 release SCL; Q2 pull SDA; Q3 pull SCL. A repeated start works because SCL is already low entering Q0.
  - BIT (8 iterations, MSB first):
    - Q0: SCL low; drive SDA = tx bit on write (release when the bit is 1), release SDA on read.
    - Q1, Q2: SCL released.
    - End of Q2: sample sda_in into the shift register.
    - Q3: pull SCL.
  - ACK: same four quarters.
    - Write: SDA released; the sample goes to RXACK.
    - Read: SDA driven = MACK. At the end, the shift register goes to RXDATA.
  - STOP: Q0 pull SDA with SCL low; Q1 release SCL; Q2 hold; Q3 release SDA.
- Clock stretching: in any quarter where SCL is released, the quarter counter holds at its reload value until scl_in=1.
- Idle bus: scl_oe=sda_oe=0.
- After a byte or START without STOP, SCL stays pulled low (bus held) until the next command.
- PRESCALE=0 gives 1-clk quarters and must work.
- No multi-master arbitration: sda_in is not compared while transmitting.

Test Plan:
- Reset: rst_n=0 → scl_oe=sda_oe=0, irq=0, STATUS read=0x00, PRESCALE read=8'd13.
- Write byte: PRESCALE=3, DATA=0xA5, CTRL=0x8B, slave model acks → pad bits 1,0,1,0,0,1,0,1 then STOP, each bit 16 clks; STATUS=0x84, irq=1. A following CTRL write of 0x80 → irq=0.
- Read byte: CTRL=0x17, slave returns 0x3C → RXDATA=0x3C; master drives SDA released (NACK) in the ACK slot, then STOP; STATUS[2]=1.
- NACK: slave releases SDA on ACK of a write → STATUS[1]=1.
- Stretching and busy writes: slave holds SCL low 100 clks during bit 3 → that quarter extends by 100 clks and the data is intact. A DATA write while BUSY leaves TXDATA unchanged.
- Reset mid-transfer: assert rst_n=0 during bit 5 → both oe=0 next edge. A later CTRL=0x0B transfers normally.

Source files
------------

// File: rtl/i2c_master_if.sv
// CSR bus and open-drain I2C pad signals of the byte-level I2C initiator.
interface i2c_master_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic [AW-1:0] csr_a;
  logic [DW-1:0] csr_di;
  logic          csr_we;
  logic [DW-1:0] csr_do;
  logic          scl_in;
  logic          scl_oe;
  logic          sda_in;
  logic          sda_oe;
  logic          irq;

  modport master (
    output csr_a, csr_di, csr_we, scl_in, sda_in,
    input  csr_do, scl_oe, sda_oe, irq
  );

  modport slave (
    input  csr_a, csr_di, csr_we, scl_in, sda_in,
    output csr_do, scl_oe, sda_oe, irq
  );
endinterface

// File: rtl/i2c_master.sv
// Byte-level I2C initiator: START / one byte / STOP sequencing on quarter-period
// ticks, controlled through three CSRs.
module i2c_master #(
  parameter logic [4:0] BASE_ADDR        = 5'h18,
  parameter logic [7:0] DEFAULT_PRESCALE = 8'd13
) (
  input logic         clk,
  input logic         rst_n,
  i2c_master_if.slave bus
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned QW = 2;
  localparam int unsigned BW = 3;

  localparam logic [AW-1:0] A_CTRL = BASE_ADDR;
  localparam logic [AW-1:0] A_DATA = BASE_ADDR + AW'(1);
  localparam logic [AW-1:0] A_PRE  = BASE_ADDR + AW'(2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t        state, state_n;
  logic [QW-1:0] q, q_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DW-1:0] shreg, shreg_n;
  logic [DW-1:0] txdata, txdata_n;
  logic [DW-1:0] rxdata, rxdata_n;
  logic [DW-1:0] prescale, prescale_n;
  logic          ie, ie_n;
  logic          done, done_n;
  logic          rxack, rxack_n;
  logic          do_stop, do_stop_n;
  logic          do_byte, do_byte_n;
  logic          is_read, is_read_n;
  logic          mack, mack_n;
  logic          scl_oe_r, scl_oe_n;
  logic          sda_oe_r, sda_oe_n;
  logic [DW-1:0] csr_do_r, csr_do_n;
  logic          irq_r, irq_n;

  logic busy_c, stretch_c, tick_c, enter_c;
  logic unused_di;

  assign unused_di  = ^bus.csr_di[6:5];
  assign busy_c     = (state != S_IDLE);
  // Released SCL still low on the pad means a responder is stretching the clock.
  assign stretch_c  = busy_c && !scl_oe_r && !bus.scl_in;
  assign tick_c     = busy_c && (cnt == '0) && !stretch_c;

  assign bus.scl_oe = scl_oe_r;
  assign bus.sda_oe = sda_oe_r;
  assign bus.csr_do = csr_do_r;
  assign bus.irq    = irq_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      q        <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txdata   <= '0;
      rxdata   <= '0;
      prescale <= DEFAULT_PRESCALE;
      ie       <= 1'b0;
      done     <= 1'b0;
      rxack    <= 1'b0;
      do_stop  <= 1'b0;
      do_byte  <= 1'b0;
      is_read  <= 1'b0;
      mack     <= 1'b0;
      scl_oe_r <= 1'b0;
      sda_oe_r <= 1'b0;
      csr_do_r <= '0;
      irq_r    <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      txdata   <= txdata_n;
      rxdata   <= rxdata_n;
      prescale <= prescale_n;
      ie       <= ie_n;
      done     <= done_n;
      rxack    <= rxack_n;
      do_stop  <= do_stop_n;
      do_byte  <= do_byte_n;
      is_read  <= is_read_n;
      mack     <= mack_n;
      scl_oe_r <= scl_oe_n;
      sda_oe_r <= sda_oe_n;
      csr_do_r <= csr_do_n;
      irq_r    <= irq_n;
    end
  end

  always_comb begin
    state_n    = state;
    q_n        = q;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    txdata_n   = txdata;
    rxdata_n   = rxdata;
    prescale_n = prescale;
    ie_n       = ie;
    done_n     = done;
    rxack_n    = rxack;
    do_stop_n  = do_stop;
    do_byte_n  = do_byte;
    is_read_n  = is_read;
    mack_n     = mack;
    scl_oe_n   = scl_oe_r;
    sda_oe_n   = sda_oe_r;
    csr_do_n   = '0;
    enter_c    = 1'b0;

    // CSR writes; while busy only IE is writable
    if (bus.csr_we) begin
      if (bus.csr_a == A_CTRL) begin
        ie_n = bus.csr_di[7];
        if (!busy_c) begin
          done_n = 1'b0;
          if (|bus.csr_di[3:0]) begin
            enter_c   = 1'b1;
            q_n       = '0;
            bit_cnt_n = '0;
            shreg_n   = txdata;
            do_stop_n = bus.csr_di[1];
            do_byte_n = bus.csr_di[2] | bus.csr_di[3];
            is_read_n = bus.csr_di[2] & ~bus.csr_di[3];
            mack_n    = bus.csr_di[4];
            if (bus.csr_di[0])                       state_n = S_START;
            else if (bus.csr_di[2] | bus.csr_di[3])  state_n = S_BIT;
            else                                     state_n = S_STOP;
          end
        end
      end else if (bus.csr_a == A_DATA && !busy_c) begin
        txdata_n = bus.csr_di;
      end else if (bus.csr_a == A_PRE && !busy_c) begin
        prescale_n = bus.csr_di;
      end
    end

    // Quarter sequencing
    if (tick_c) begin
      enter_c = 1'b1;
      q_n     = QW'(q + QW'(1));
      case (state)
        S_START: if (q == QW'(3)) begin
          if (do_byte)      state_n = S_BIT;
          else if (do_stop) state_n = S_STOP;
          else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
        S_BIT: begin
          if (q == QW'(2)) shreg_n = {shreg[DW-2:0], bus.sda_in};
          if (q == QW'(3)) begin
            if (bit_cnt == BW'(7)) state_n = S_ACK;
            else                   bit_cnt_n = BW'(bit_cnt + BW'(1));
          end
        end
        S_ACK: begin
          if (q == QW'(2) && !is_read) rxack_n = bus.sda_in;
          if (q == QW'(3)) begin
            if (is_read) rxdata_n = shreg;
            if (do_stop) state_n = S_STOP;
            else begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end
        end
        S_STOP: if (q == QW'(3)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
        default: ;
      endcase
    end else if (busy_c) begin
      cnt_n = stretch_c ? prescale : DW'(cnt - DW'(1));
    end

    // Line levels are set once on entry to each quarter
    if (enter_c) begin
      cnt_n = prescale;
      case (state_n)
        S_START: case (q_n)
          2'd0:    sda_oe_n = 1'b0;
          2'd1:    scl_oe_n = 1'b0;
          2'd2:    sda_oe_n = 1'b1;
          default: scl_oe_n = 1'b1;
        endcase
        S_BIT: case (q_n)
          2'd0: begin
            scl_oe_n = 1'b1;
            sda_oe_n = is_read_n ? 1'b0 : ~shreg_n[DW-1];
          end
          2'd1:    scl_oe_n = 1'b0;
          2'd3:    scl_oe_n = 1'b1;
          default: ;
        endcase
        S_ACK: case (q_n)
          2'd0: begin
            scl_oe_n = 1'b1;
            sda_oe_n = is_read_n ? ~mack_n : 1'b0;
          end
          2'd1:    scl_oe_n = 1'b0;
          2'd3:    scl_oe_n = 1'b1;
          default: ;
        endcase
        S_STOP: case (q_n)
          2'd0: begin
            scl_oe_n = 1'b1;
            sda_oe_n = 1'b1;
          end
          2'd1:    scl_oe_n = 1'b0;
          2'd3:    sda_oe_n = 1'b0;
          default: ;
        endcase
        default: ;
      endcase
    end

    // Registered read mux
    if (bus.csr_a == A_CTRL)      csr_do_n = {ie, 4'b0000, done, rxack, busy_c};
    else if (bus.csr_a == A_DATA) csr_do_n = rxdata;
    else if (bus.csr_a == A_PRE)  csr_do_n = prescale;

    irq_n = done_n & ie_n;
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with an open-drain pad model and a simple
// responder that acks, returns read data and can stretch one clock.
module tb_i2c_master;
  localparam logic [4:0] A_CTRL = 5'h18;
  localparam logic [4:0] A_DATA = 5'h19;
  localparam logic [4:0] A_PRE  = 5'h1A;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_master_if bus();

  i2c_master #(.BASE_ADDR(5'h18), .DEFAULT_PRESCALE(8'd13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Responder controls (driven by the stimulus) and state (driven by the model)
  logic       rd_mode, ack_en, stretch_en;
  logic [7:0] rd_byte;
  logic       slv_sda_pull = 1'b0;
  logic       slv_scl_hold = 1'b0;
  logic       stretch_used = 1'b0;
  int         hcnt = 0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         nbits = 0, stops = 0, cyc = 0;
  logic       bits [0:9];
  int         rise_t [0:9];

  assign bus.scl_in = ~(bus.scl_oe | slv_scl_hold);
  assign bus.sda_in = ~(bus.sda_oe | slv_sda_pull);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    scl_p <= bus.scl_in;
    sda_p <= bus.sda_in;
    if (scl_p && bus.scl_in && sda_p && !bus.sda_in) begin
      nbits        <= 0;
      slv_sda_pull <= 1'b0;
    end else if (scl_p && bus.scl_in && !sda_p && bus.sda_in) begin
      stops        <= stops + 1;
      slv_sda_pull <= 1'b0;
    end else if (!scl_p && bus.scl_in) begin
      if (nbits < 10) begin
        bits[nbits]   <= bus.sda_in;
        rise_t[nbits] <= cyc;
      end
      nbits <= nbits + 1;
    end else if (scl_p && !bus.scl_in) begin
      if (rd_mode && nbits < 8)        slv_sda_pull <= ~rd_byte[7-nbits];
      else if (!rd_mode && nbits == 8) slv_sda_pull <= ack_en;
      else                             slv_sda_pull <= 1'b0;
      if (stretch_en && !stretch_used && nbits == 3) begin
        slv_scl_hold <= 1'b1;
        stretch_used <= 1'b1;
      end
    end
    // Count only cycles where the master has released SCL
    if (slv_scl_hold && !bus.scl_oe) begin
      hcnt <= hcnt + 1;
      if (hcnt == 99) begin
        slv_scl_hold <= 1'b0;
        hcnt         <= 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    @(negedge clk);
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.csr_a = a;
    @(negedge clk);
    d = bus.csr_do;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    bus.csr_a = A_CTRL;
    @(negedge clk);
    @(negedge clk);
    while (bus.csr_do[0] !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < max), 32'd1);
  endtask

  function automatic logic [7:0] rx_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits[i];
    return b;
  endfunction

  logic [7:0] rd;
  int         stops0, n;

  initial begin
    bus.csr_a  = '0;
    bus.csr_di = '0;
    bus.csr_we = 1'b0;
    rst_n      = 1'b0;
    rd_mode    = 1'b0;
    ack_en     = 1'b1;
    rd_byte    = 8'h00;
    stretch_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", 32'(bus.scl_oe), 32'd0);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    rst_n = 1'b1;
    csr_rd(A_CTRL, rd); chk("rst_status", 32'(rd), 32'h00);
    csr_rd(A_PRE, rd);  chk("rst_prescale", 32'(rd), 32'd13);

    // Write 0xA5 with START+STOP, IE set
    stops0 = stops;
    csr_wr(A_PRE, 8'd3);
    csr_wr(A_DATA, 8'hA5);
    csr_wr(A_CTRL, 8'h8B);
    wait_idle("wr_timeout", 2000);
    chk("wr_byte", 32'(rx_byte()), 32'hA5);
    chk("wr_ack_slot", 32'(bits[8]), 32'd0);
    chk("wr_period_01", 32'(rise_t[1] - rise_t[0]), 32'd16);
    chk("wr_period_67", 32'(rise_t[7] - rise_t[6]), 32'd16);
    chk("wr_stop", 32'(stops - stops0), 32'd1);
    chk("wr_irq", 32'(bus.irq), 32'd1);
    csr_rd(A_CTRL, rd); chk("wr_status", 32'(rd), 32'h84);
    csr_wr(A_CTRL, 8'h80);
    chk("irq_clear", 32'(bus.irq), 32'd0);

    // Read with NACK from master
    rd_mode = 1'b1;
    rd_byte = 8'h3C;
    csr_wr(A_CTRL, 8'h17);
    wait_idle("rd_timeout", 2000);
    rd_mode = 1'b0;
    chk("rd_mack_slot", 32'(bits[8]), 32'd1);
    csr_rd(A_DATA, rd); chk("rd_rxdata", 32'(rd), 32'h3C);
    csr_rd(A_CTRL, rd); chk("rd_status", 32'(rd), 32'h04);

    // Responder NACKs a write
    ack_en = 1'b0;
    csr_wr(A_DATA, 8'h5A);
    csr_wr(A_CTRL, 8'h0B);
    wait_idle("nack_timeout", 2000);
    ack_en = 1'b1;
    chk("nack_byte", 32'(rx_byte()), 32'h5A);
    csr_rd(A_CTRL, rd); chk("nack_status", 32'(rd), 32'h06);

    // One-clock quarters
    csr_wr(A_PRE, 8'd0);
    csr_wr(A_DATA, 8'h81);
    csr_wr(A_CTRL, 8'h0B);
    wait_idle("ps0_timeout", 500);
    chk("ps0_byte", 32'(rx_byte()), 32'h81);
    chk("ps0_period", 32'(rise_t[2] - rise_t[1]), 32'd4);
    csr_rd(A_CTRL, rd); chk("ps0_status", 32'(rd), 32'h04);

    // Clock stretching on bit 3 plus a DATA write while busy
    csr_wr(A_PRE, 8'd3);
    csr_wr(A_DATA, 8'hC3);
    stretch_en = 1'b1;
    csr_wr(A_CTRL, 8'h0B);
    csr_wr(A_DATA, 8'hFF);
    wait_idle("str_timeout", 3000);
    stretch_en = 1'b0;
    chk("str_byte", 32'(rx_byte()), 32'hC3);
    chk("str_period", 32'(rise_t[3] - rise_t[2]), 32'd116);
    chk("str_period_next", 32'(rise_t[4] - rise_t[3]), 32'd16);
    csr_wr(A_CTRL, 8'h0B);
    wait_idle("busywr_timeout", 2000);
    chk("busywr_txdata", 32'(rx_byte()), 32'hC3);

    // Reset in the middle of bit 5 (master pulling SDA there)
    csr_wr(A_DATA, 8'h3A);
    csr_wr(A_CTRL, 8'h0B);
    n = 0;
    while (nbits != 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_bit5", 32'(n < 1000), 32'd1);
    chk("mid_sda_before", 32'(bus.sda_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_scl_oe", 32'(bus.scl_oe), 32'd0);
    chk("mid_sda_oe", 32'(bus.sda_oe), 32'd0);
    rst_n = 1'b1;
    csr_rd(A_PRE, rd); chk("mid_prescale", 32'(rd), 32'd13);
    csr_wr(A_DATA, 8'h96);
    csr_wr(A_CTRL, 8'h0B);
    wait_idle("post_timeout", 5000);
    chk("post_byte", 32'(rx_byte()), 32'h96);
    chk("post_period", 32'(rise_t[5] - rise_t[4]), 32'd56);
    csr_rd(A_CTRL, rd); chk("post_status", 32'(rd), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
